// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg
// Shared definitions for the ARM pipeline memory subsystem.
//   sram_state_t    : access sequencer states (IDLE, LOW, HIGH, DONE)
//   SRAM_BASE_ADDR  : core byte address that maps to SRAM half-word 0
//   HALF_LO/HALF_HI : half-word select bit appended to the word index
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam int SRAM_BASE_ADDR = 1024;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter
// Loadable down-counter with a terminal-count flag. Loading wins over
// counting; the counter parks at zero once it gets there.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load        : load load_value on the next edge
//   load_value  : value to count down from
//   en          : decrement by one per cycle while nonzero
//   tc          : high while the count is zero
module mem_wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Count register: reload has priority, then decrement toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && !tc) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl
// MEM-stage memory controller: turns 32-bit word loads/stores into two
// 16-bit SRAM accesses (low half first), each held for WAIT_CYCLES cycles.
// ready is low while an access is in flight so the core freezes its pipeline.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en, rd_en        : store / load request, held until ready
//   address, wr_data    : word-aligned byte address, store data
//   rd_data             : load result, valid when ready=1 after a load
//   ready               : 0 = freeze pipeline
//   sram_addr           : SRAM half-word address
//   sram_dq_out/oe/in   : SRAM data bus (oe=1 when controller drives it)
//   sram_we_n           : SRAM write enable, active low
//   stall_count         : only with MEM_STALL_STATS_EN, saturating count of
//                         cycles a request waited with ready=0
module mem_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int DATA_LEN      = 32,
  parameter int ADDRESS_LEN   = 32,
  parameter int SRAM_DATA_LEN = 16,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int WAIT_CYCLES   = 3,
  parameter int BASE_ADDR     = SRAM_BASE_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDRESS_LEN-1:0]   address,
  input  logic [DATA_LEN-1:0]      wr_data,
  output logic [DATA_LEN-1:0]      rd_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_we_n
`ifdef MEM_STALL_STATS_EN
  , output logic [31:0]            stall_count
`endif
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

  sram_state_t state, state_next;

  logic req;
  logic cnt_load, cnt_en, cnt_tc;

  logic [SRAM_ADDR_LEN-2:0]          widx_new, widx_q;
  logic [DATA_LEN-SRAM_DATA_LEN-1:0] wdata_hi_q;
  logic [SRAM_DATA_LEN-1:0]          low_half_q;
  logic                              store_q;

  assign req = rd_en | wr_en;

  // Word index into the SRAM; the cast drops upper bits so out-of-range
  // addresses simply wrap.
  assign widx_new = (SRAM_ADDR_LEN-1)'((address - ADDRESS_LEN'(BASE_ADDR)) >> 2);

  // Each phase reloads the counter on entry and leaves on terminal count,
  // so a phase lasts exactly WAIT_CYCLES cycles.
  mem_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (CNT_RELOAD),
    .en         (cnt_en),
    .tc         (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, counter control and ready.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_next = LOW;
          cnt_load   = 1'b1;
        end
      end
      LOW: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_next = HIGH;
          cnt_load   = 1'b1;
        end
      end
      HIGH: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // A request still held here belongs to the next instruction and
        // is picked up again from IDLE.
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latching and SRAM bus drive. Bus outputs change on phase
  // entry so we_n/oe cover the whole LOW and HIGH phases of a store.
  // The low half of a load is parked until the high half arrives so
  // rd_data only ever changes to a complete word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx_q      <= '0;
      wdata_hi_q  <= '0;
      store_q     <= 1'b0;
      low_half_q  <= '0;
      rd_data     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            widx_q      <= widx_new;
            wdata_hi_q  <= wr_data[DATA_LEN-1:SRAM_DATA_LEN];
            store_q     <= wr_en;
            sram_addr   <= {widx_new, HALF_LO};
            sram_dq_out <= wr_data[SRAM_DATA_LEN-1:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        LOW: begin
          if (cnt_tc) begin
            if (!store_q) begin
              low_half_q <= sram_dq_in;
            end
            sram_addr   <= {widx_q, HALF_HI};
            sram_dq_out <= wdata_hi_q;
          end
        end
        HIGH: begin
          if (cnt_tc) begin
            if (!store_q) begin
              rd_data <= {sram_dq_in, low_half_q};
            end
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_STALL_STATS_EN
  // Saturating count of cycles the core spent frozen on a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (req && !ready && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
